// File: rtl/pwm_gradient_multi_if.sv
// Control and status bundle for pwm_gradient_multi.
// master drives configuration, slave is the PWM/fade engine.
interface pwm_gradient_multi_if #(
   parameter int N = 3,
   parameter int R = 8
);
   logic              en;
   logic              restart;
   logic [31:0]       dvsr;
   logic [31:0]       grad_dvsr;
   logic [R-1:0]      step;
   logic [2*N-1:0]    mode;
   logic [N-1:0]      pwm_out;
   logic [N*(R+1)-1:0] duty_mon;
   logic [N-1:0]      wrap;

   modport master (
      output en, restart, dvsr, grad_dvsr, step, mode,
      input  pwm_out, duty_mon, wrap
   );

   modport slave (
      input  en, restart, dvsr, grad_dvsr, step, mode,
      output pwm_out, duty_mon, wrap
   );
endinterface

// File: rtl/pwm_gradient_multi.sv
// N-channel PWM with shared prescaler/gradient timer and per-channel fade.
// Optional PWM_GAMMA_EN: compare against registered (duty*duty)>>R.
module pwm_gradient_multi #(
   parameter int N = 3,
   parameter int R = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pwm_gradient_multi_if.slave  bus
);
   localparam int W = R + 1;
   localparam logic [R+1:0] FULL  = {2'b01, {R{1'b0}}};
   localparam logic [W-1:0] FULLD = {1'b1, {R{1'b0}}};
   localparam logic [R-1:0] ONE_Q = {{(R-1){1'b0}}, 1'b1};

   logic [31:0]  pcnt;
   logic [31:0]  gcnt;
   logic [R-1:0] q;
   logic [W-1:0] duty   [N];
   logic [W-1:0] duty_n [N];
   logic [W-1:0] cmp    [N];
   logic [N-1:0] dir;
   logic [N-1:0] dir_n;
   logic [N-1:0] wrap_n;
   logic [N-1:0] hit;
   logic [N-1:0] pwm;
   logic [N-1:0] wrap_q;
   logic         ptick;
   logic         gtick;

   assign ptick = (pcnt == bus.dvsr);
   assign gtick = (gcnt == bus.grad_dvsr);

   // dir: 0 = rising, 1 = falling; only TRI consults or changes it
   always_comb begin
      logic [R+1:0] d;
      logic [R+1:0] s;
      logic [R+1:0] sum;
      logic [R+1:0] diff;
      d    = '0;
      s    = {2'b00, bus.step};
      sum  = '0;
      diff = '0;
      for (int i = 0; i < N; i++) begin
         d         = {1'b0, duty[i]};
         sum       = d + s;
         diff      = d - s;
         duty_n[i] = duty[i];
         dir_n[i]  = dir[i];
         wrap_n[i] = 1'b0;
         unique case (bus.mode[2*i +: 2])
            2'b00: ;
            2'b01: begin
               if (sum > FULL) begin
                  duty_n[i] = '0;
                  wrap_n[i] = 1'b1;
               end else begin
                  duty_n[i] = sum[W-1:0];
               end
            end
            2'b10: begin
               if (d < s) begin
                  duty_n[i] = FULLD;
                  wrap_n[i] = 1'b1;
               end else begin
                  duty_n[i] = diff[W-1:0];
               end
            end
            2'b11: begin
               if (!dir[i]) begin
                  if (sum >= FULL) begin
                     duty_n[i] = FULLD;
                     dir_n[i]  = 1'b1;
                  end else begin
                     duty_n[i] = sum[W-1:0];
                  end
               end else if (d <= s) begin
                  duty_n[i] = '0;
                  dir_n[i]  = 1'b0;
                  wrap_n[i] = 1'b1;
               end else begin
                  duty_n[i] = diff[W-1:0];
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt   <= '0;
         gcnt   <= '0;
         q      <= '0;
         dir    <= '0;
         wrap_q <= '0;
         duty   <= '{default: '0};
      end else if (!bus.en) begin
         wrap_q <= '0;
      end else if (bus.restart) begin
         pcnt   <= '0;
         gcnt   <= '0;
         q      <= '0;
         dir    <= '0;
         wrap_q <= '0;
         duty   <= '{default: '0};
      end else begin
         pcnt <= ptick ? 32'd0 : pcnt + 32'd1;
         gcnt <= gtick ? 32'd0 : gcnt + 32'd1;
         if (ptick) q <= q + ONE_Q;
         if (gtick) begin
            duty   <= duty_n;
            dir    <= dir_n;
            wrap_q <= wrap_n;
         end else begin
            wrap_q <= '0;
         end
      end
   end

`ifdef PWM_GAMMA_EN
   logic [2*R+1:0] sq [N];

   always_comb begin
      for (int i = 0; i < N; i++)
         sq[i] = {{W{1'b0}}, duty[i]} * {{W{1'b0}}, duty[i]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cmp <= '{default: '0};
      else for (int i = 0; i < N; i++) cmp[i] <= sq[i][2*R:R];
   end
`else
   always_comb cmp = duty;
`endif

   always_comb begin
      for (int i = 0; i < N; i++) hit[i] = ({1'b0, q} < cmp[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pwm <= '0;
      else        pwm <= bus.en ? hit : '0;
   end

   always_comb begin
      bus.duty_mon = '0;
      for (int i = 0; i < N; i++) bus.duty_mon[i*W +: W] = duty[i];
   end

   assign bus.pwm_out = pwm;
   assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_pwm_gradient_multi.sv
// Directed bench for pwm_gradient_multi (N=3, R=4).
// Expected duty/wrap tables are hand-derived from the fade rules.
module tb_pwm_gradient_multi;
   localparam int N = 3;
   localparam int R = 4;
   localparam int W = R + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pwm_gradient_multi_if #(.N(N), .R(R)) bus ();

   pwm_gradient_multi #(.N(N), .R(R)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;
   int e0 [8];
   int e1 [8];
   int e2 [8];
   int ew [8];
   int h0, h1, h2, bad0, bad1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] dm(input int ch);
      return bus.duty_mon[ch*W +: W];
   endfunction

   task automatic do_restart(input logic [R-1:0] s, input logic [2*N-1:0] m);
      bus.step    = s;
      bus.mode    = m;
      bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
   endtask

   task automatic run_tab(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check($sformatf("%s_d0_%0d", tag, k), dm(0), e0[k]);
         check($sformatf("%s_d1_%0d", tag, k), dm(1), e1[k]);
         check($sformatf("%s_d2_%0d", tag, k), dm(2), e2[k]);
         check($sformatf("%s_wr_%0d", tag, k), bus.wrap, ew[k]);
      end
   endtask

   initial begin
      bus.en        = 1'b0;
      bus.restart   = 1'b0;
      bus.dvsr      = 32'd0;
      bus.grad_dvsr = 32'd0;
      bus.step      = '0;
      bus.mode      = '0;
      repeat (2) @(negedge clk);
      check("rst_pwm", bus.pwm_out, 0);
      check("rst_duty", bus.duty_mon, 0);
      check("rst_wrap", bus.wrap, 0);
      rst_n  = 1'b1;
      bus.en = 1'b1;

      // ch0 UP, ch1 HOLD, ch2 DOWN, step 5
      do_restart(4'd5, 6'b100001);
      check("a_start", dm(0), 0);
      e0 = '{5, 10, 15, 0, 5, 0, 0, 0};
      e1 = '{0, 0, 0, 0, 0, 0, 0, 0};
      e2 = '{16, 11, 6, 1, 16, 0, 0, 0};
      ew = '{4, 0, 0, 1, 4, 0, 0, 0};
      run_tab("up", 5);

      // ch0 TRI, ch1 UP, ch2 DOWN, step 6
      do_restart(4'd6, 6'b100111);
      e0 = '{6, 12, 16, 10, 4, 0, 6, 0};
      e1 = '{6, 12, 0, 6, 12, 0, 6, 0};
      e2 = '{16, 10, 4, 16, 10, 4, 16, 0};
      ew = '{4, 0, 2, 4, 0, 3, 4, 0};
      run_tab("tri", 7);

      // all DOWN, step 3
      do_restart(4'd3, 6'b101010);
      e0 = '{16, 13, 10, 7, 4, 1, 16, 13};
      e1 = e0;
      e2 = e0;
      ew = '{7, 0, 0, 0, 0, 0, 7, 0};
      run_tab("dn", 8);

      // restart against a gtick while ch1 is falling from 10
      do_restart(4'd6, 6'b001100);
      repeat (4) @(negedge clk);
      check("e_pre", dm(1), 10);
      bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
      check("e_duty", dm(1), 0);
      check("e_wrap", bus.wrap, 0);
      @(negedge clk);
      check("e_dirup", dm(1), 6);

      // freeze
      bus.en = 1'b0;
      bad0 = 0;
      bad1 = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.pwm_out != 0) bad0++;
         if (bus.duty_mon != 15'd192) bad1++;
      end
      check("f_pwm", bad0, 0);
      check("f_duty", bad1, 0);
      bus.en = 1'b1;
      @(negedge clk);
      check("f_resume", dm(1), 12);

      // static duty: ch0=4, ch1=0, ch2=16
      do_restart(4'd4, 6'b100001);
      @(negedge clk);
      check("d_ch0", dm(0), 4);
      check("d_ch2", dm(2), 16);
      bus.mode = '0;
      repeat (3) @(negedge clk);
      h0 = 0; h1 = 0; h2 = 0;
      repeat (32) begin
         @(negedge clk);
         h0 += int'(bus.pwm_out[0]);
         h1 += int'(bus.pwm_out[1]);
         h2 += int'(bus.pwm_out[2]);
      end
`ifdef PWM_GAMMA_EN
      check("d_hi0", h0, 2);
`else
      check("d_hi0", h0, 8);
`endif
      check("d_hi1", h1, 0);
      check("d_hi2", h2, 32);
      bus.dvsr = 32'd1;
      repeat (3) @(negedge clk);
      h0 = 0;
      repeat (64) begin
         @(negedge clk);
         h0 += int'(bus.pwm_out[0]);
      end
`ifdef PWM_GAMMA_EN
      check("d_div_hi0", h0, 4);
`else
      check("d_div_hi0", h0, 16);
`endif
      bus.dvsr = 32'd0;

      // asynchronous reset mid-cycle
      check("g_pre", bus.pwm_out[2], 1);
      #2 rst_n = 1'b0;
      #1;
      check("g_pwm", bus.pwm_out, 0);
      check("g_duty", bus.duty_mon, 0);
      check("g_wrap", bus.wrap, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bad0 = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.pwm_out != 0) bad0++;
      end
      check("g_post", bad0, 0);

      // step 0 holds in every mode
      bus.step = '0;
      bus.mode = 6'b101101;
      bad0 = 0;
      bad1 = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.wrap != 0) bad0++;
         if (bus.duty_mon != 0) bad1++;
      end
      check("z_wrap", bad0, 0);
      check("z_duty", bad1, 0);

      // gradient period of 4 clocks
      bus.grad_dvsr = 32'd3;
      do_restart(4'd5, 6'b000001);
      e0 = '{0, 0, 0, 5, 5, 5, 5, 10};
      e1 = '{0, 0, 0, 0, 0, 0, 0, 0};
      e2 = e1;
      ew = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_tab("gd", 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pwm_gradient_multi.md
Name: pwm_gradient_multi

Overview:
- N-channel PWM generator with a built-in per-channel gradient (fade) engine; the parametrised successor of the single-channel top-level fader.
- All channels share one PWM prescaler and one gradient timer. Each channel has its own duty register, mode (hold / up-ramp / down-ramp / triangle "breathing") and wrap pulse.
- Drives RGB LED pins directly, or any bank of PWM loads.

Parameters:
- N, 3, number of channels
- R, 8, PWM resolution in bits; duty range is 0..2^R inclusive (R+1 bits)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; low freezes all counters and forces pwm_out to 0
- restart  in  1  synchronous one-cycle pulse; restarts all channels from 0
- dvsr  in  32  PWM prescaler divisor; tick period is dvsr+1 clocks
- grad_dvsr  in  32  gradient step period minus 1, in clocks
- step  in  R  duty increment per gradient tick, shared by all channels
- mode  in  2*N  per channel: 00 HOLD, 01 UP, 10 DOWN, 11 TRI
- pwm_out  out  N  registered PWM outputs
- duty_mon  out  N*(R+1)  current duty register of each channel (channel i at bits [i*(R+1) +: R+1])
- wrap  out  N  one-cycle pulse when a channel completes a gradient cycle

Behaviour:
- Reset (async, rst_n=0): all counters 0, every duty 0, every dir=UP, pwm_out=0, wrap=0.
- Prescaler pcnt:
  - counts 0..dvsr; ptick when pcnt==dvsr, then pcnt returns to 0.
  - dvsr=0 gives ptick every cycle.
- PWM counter q (R bits):
  - increments on ptick; wraps 2^R-1 -> 0.
- pwm_out[i]:
  - registered each cycle as (q < duty[i]), so it lags q by 1 cycle.
  - duty=0: constant low. duty=2^R: constant high.
- Gradient timer gcnt:
  - counts 0..grad_dvsr; gtick when gcnt==grad_dvsr, then gcnt returns to 0.
  - Independent of ptick.
- Per-channel update on gtick, using (R+2)-bit arithmetic, no silent truncation:
  - HOLD: duty unchanged.
  - UP: if duty+step > 2^R then duty<=0 and wrap=1; else duty<=duty+step.
  - DOWN: if duty < step then duty<=2^R and wrap=1; else duty<=duty-step.
  - TRI, dir=UP: if duty+step >= 2^R then duty<=2^R and dir<=DOWN; else duty+=step.
  - TRI, dir=DOWN: if duty <= step then duty<=0, dir<=UP, wrap=1; else duty-=step.
- step=0: duty holds in every mode; wrap never fires.
- Mode changes are sampled only on gtick. dir is retained across mode changes; entering TRI continues in the stored dir.
- wrap is high for exactly the one cycle after the qualifying gtick; 0 otherwise.
- en=0:
  - pcnt, q, gcnt and duty all freeze; pwm_out<=0; wrap<=0.
  - On re-enable, counting resumes from the frozen values.
- restart=1 (only effective when en=1):
  - pcnt, q, gcnt <= 0; every duty <= 0; dir <= UP; wrap <= 0.
  - Has priority over a simultaneous gtick.
- Changing dvsr or grad_dvsr mid-count:
  - if the counter is already above the new limit, it runs to 2^32-1, wraps to 0, and fires its tick on the next match.
  - No glitch on pwm_out beyond the normal comparison.

Optional Feature:
- Macro PWM_GAMMA_EN.
- Defined: the comparison value is duty_g = (duty*duty) >> R, computed in 2R+2 bits and registered. This adds 1 cycle of duty-to-output latency. duty=2^R still maps to 2^R (constant high). duty_mon still reports the linear duty.
- Undefined: the comparison uses the linear duty directly; the squarer and its register are not present.

Test Plan:
- Reset and freeze: rst_n=0 mid-run with duty=37 -> pwm_out=0, duty_mon=0, wrap=0 immediately (asynchronous); after release, pwm_out stays 0 until a duty update.
- Static duty, R=4, dvsr=0, grad_dvsr=3, step=4, mode=HOLD on ch0 after ramping ch0 to duty 4 -> pwm_out[0] high for 4 of every 16 clocks. At duty 0 it is never high; at duty 16 it is always high.
- UP ramp, R=4, step=5, grad_dvsr=0 -> duty_mon sequence 0,5,10,15,0 with wrap pulse on the 15->0 transition, period 4 gticks.
- TRI, R=4, step=6 -> duty 0,6,12,16,10,4,0,6; wrap only on the arrival at 0; direction flips at 16 and at 0.
- DOWN from reset, step=3 -> duty 16 (wrap),13,10,...,1,16 (wrap).
- restart coincident with gtick while ch1 TRI dir=DOWN duty=10 -> next cycle duty=0, dir=UP, no wrap. en=0 for 100 clocks -> duty_mon unchanged, pwm_out=0 throughout.
